// File: rtl/lin_slave_resp_sequencer_if.sv
// LIN slave response sequencer bus bundle.
// Decoder request, RAM read port and UART TX handshake.
interface lin_slave_resp_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        byte_cnt;
  logic [7:0]        pid;
  logic              abort;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, base_addr, byte_cnt, pid,
    output abort, ram_data, tx_ready,
    input  ram_addr, tx_data, tx_valid,
    input  busy, done, err
  );

  modport slave (
    input  start, base_addr, byte_cnt, pid,
    input  abort, ram_data, tx_ready,
    output ram_addr, tx_data, tx_valid,
    output busy, done, err
  );
endinterface

// File: rtl/lin_slave_resp_sequencer.sv
// LIN slave response sequencer: RAM words -> UART bytes + checksum.
// LIN_ENHANCED_CHKSUM_EN: seed checksum with pid (enhanced).
module lin_slave_resp_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic reset,
  lin_slave_resp_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    CHK,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0]        len;
  logic [2:0]        idx;
  logic [7:0]        sum;
  logic [DATA_W-1:0] word_buf;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  logic [7:0] init;
  logic [7:0] cur_byte;
  logic [8:0] s9;
  logic       tx_valid;
  logic       hs;
  logic       last;
  logic       go;
  logic       bad;
  logic       idle;

`ifdef LIN_ENHANCED_CHKSUM_EN
  assign init = bus.pid;
`else
  logic unused_pid;
  assign unused_pid = ^bus.pid;
  assign init = 8'h00;
`endif

  assign idle     = (state == IDLE);
  assign tx_valid = (state == SEND) || (state == CHK);
  assign hs       = tx_valid & bus.tx_ready;
  assign cur_byte = word_buf[{idx[1:0], 3'b000} +: 8];
  assign s9       = {1'b0, sum} + {1'b0, cur_byte};
  assign last     = ({1'b0, idx} + 4'd1) == len;
  assign go       = bus.start & ~bus.abort &
                    (bus.byte_cnt != 4'd0);
  assign bad      = bus.start & ~bus.abort &
                    (bus.byte_cnt == 4'd0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: abort from anywhere returns to IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (go) state_nx = FETCH;
      FETCH: state_nx = SEND;
      SEND: begin
        if (hs) begin
          if (last)
            state_nx = CHK;
          else if (idx[1:0] == 2'd3)
            state_nx = FETCH;
          else
            state_nx = SEND;
        end
      end
      CHK:   if (hs) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.abort) state_nx = IDLE;
  end

  // Datapath: request latch, word fetch, byte/checksum advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len      <= 4'd0;
      idx      <= 3'd0;
      sum      <= 8'h00;
      word_buf <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= idle & bad;
      if (idle && go) begin
        len    <= (bus.byte_cnt > 4'd8) ? 4'd8 : bus.byte_cnt;
        addr_q <= bus.base_addr;
        idx    <= 3'd0;
        sum    <= init;
      end
      if (state == FETCH && !bus.abort)
        word_buf <= bus.ram_data;
      if (state == SEND && hs && !bus.abort) begin
        sum <= s9[7:0] + {7'd0, s9[8]};
        idx <= idx + 3'd1;
        if (!last && idx[1:0] == 2'd3)
          addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Outputs decoded from state
  always_comb begin
    bus.tx_data = 8'h00;
    if (state == SEND)     bus.tx_data = cur_byte;
    else if (state == CHK) bus.tx_data = ~sum;
  end

  assign bus.tx_valid = tx_valid;
  assign bus.ram_addr = addr_q;
  assign bus.busy     = ~idle;
  assign bus.done     = (state == DONE);
  assign bus.err      = err_q;

endmodule
